// File: rtl/encoder4to2_pkg.sv
// encoder4to2_pkg: shared widths, one-hot codes and index type for the 4-to-2 encoder
package encoder4to2_pkg;
  localparam int IN_W = 4;
  localparam int OUT_W = 2;
  typedef logic [OUT_W-1:0] idx_t;
  localparam logic [IN_W-1:0] ONEHOT_0 = 4'h1;
  localparam logic [IN_W-1:0] ONEHOT_1 = 4'h2;
  localparam logic [IN_W-1:0] ONEHOT_2 = 4'h4;
  localparam logic [IN_W-1:0] ONEHOT_3 = 4'h8;
endpackage

// File: rtl/encoder4to2_core.sv
// encoder4to2_core: combinational one-hot to index encode with zero-hot/multi-hot flags
module encoder4to2_core
  import encoder4to2_pkg::*;
(
  input  logic [IN_W-1:0] d,
  output idx_t            idx,
  output logic            none,
  output logic            multi
);
  always_comb begin
    case (d)
      ONEHOT_0: idx = 2'd0;
      ONEHOT_1: idx = 2'd1;
      ONEHOT_2: idx = 2'd2;
      ONEHOT_3: idx = 2'd3;
      default:  idx = d[3] ? 2'd3 : d[2] ? 2'd2 : d[1] ? 2'd1 : 2'd0;
    endcase
    none  = (d == '0);
    multi = |(d & (d - IN_W'(1)));
  end
endmodule

// File: rtl/encoder4to2.sv
// encoder4to2: registered 4-to-2 encoder with input qualification and saturating error count
module encoder4to2
  import encoder4to2_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  d,
  input  logic             in_valid,
  input  logic             err_clr,
  output idx_t             y,
  output logic             y_valid,
  output logic             err_none,
  output logic             err_multi,
  output logic [CNT_W-1:0] err_cnt
);
  idx_t idx;
  logic none, multi;
  encoder4to2_core u_core (.d(d), .idx(idx), .none(none), .multi(multi));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y         <= '0;
      y_valid   <= 1'b0;
      err_none  <= 1'b0;
      err_multi <= 1'b0;
      err_cnt   <= '0;
    end else begin
      y_valid <= in_valid;
      if (in_valid) begin
        y         <= idx;
        err_none  <= none;
        err_multi <= multi;
      end
      err_cnt <= err_clr ? '0
               : (in_valid && (none || multi) && err_cnt != '1) ? err_cnt + CNT_W'(1)
               : err_cnt;
    end
  end
endmodule

// File: tb/tb_encoder4to2.sv
// tb_encoder4to2: directed vectors with a scoreboard queue checked by an independent monitor
module tb_encoder4to2;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, err_clr = 1'b0;
  logic [3:0] d = '0;
  logic [1:0] y, err_cnt;
  logic y_valid, err_none, err_multi;
  int checks = 0, errors = 0;
  logic [1:0] m_cnt = '0;
  typedef struct packed {logic [1:0] y; logic n; logic m; logic [1:0] c;} exp_t;
  exp_t sb[$];

  encoder4to2 #(.CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .d(d), .in_valid(in_valid), .err_clr(err_clr),
    .y(y), .y_valid(y_valid), .err_none(err_none), .err_multi(err_multi), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive(input logic [3:0] dv, input logic v, input logic c, input logic [1:0] ey,
                       input logic en, input logic em);
    exp_t e;
    @(negedge clk);
    d = dv; in_valid = v; err_clr = c;
    if (c) m_cnt = 2'd0;
    else if (v && (en || em) && m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
    if (v) begin
      e = '{y: ey, n: en, m: em, c: m_cnt};
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && y_valid) begin
      if (sb.size() == 0) check("unexpected_pulse", {7'd0, y_valid}, 8'd0);
      else begin
        e = sb.pop_front();
        check("y", {6'd0, y}, {6'd0, e.y});
        check("err_none", {7'd0, err_none}, {7'd0, e.n});
        check("err_multi", {7'd0, err_multi}, {7'd0, e.m});
        check("err_cnt", {6'd0, err_cnt}, {6'd0, e.c});
      end
    end
  end

  initial begin
    #1 check("reset_out", {y, y_valid, err_none, err_multi, err_cnt}, 8'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_release_idle", {y, y_valid, err_none, err_multi, err_cnt}, 8'd0);
    drive(4'h1, 1, 0, 2'd0, 0, 0);
    drive(4'h2, 1, 0, 2'd1, 0, 0);
    drive(4'h4, 1, 0, 2'd2, 0, 0);
    drive(4'h8, 1, 0, 2'd3, 0, 0);
    drive(4'h2, 1, 0, 2'd1, 0, 0);
    drive(4'h4, 0, 0, 2'd0, 0, 0);
    @(posedge clk); #1;
    check("gate_hold_y", {6'd0, y}, 8'd1);
    check("gate_no_valid", {7'd0, y_valid}, 8'd0);
    drive(4'h0, 1, 0, 2'd0, 1, 0);
    drive(4'hA, 1, 0, 2'd3, 0, 1);
    drive(4'h6, 1, 0, 2'd2, 0, 1);
    drive(4'h1, 1, 0, 2'd0, 0, 0);
    drive(4'hF, 1, 0, 2'd3, 0, 1);
    drive(4'h0, 1, 0, 2'd0, 1, 0);
    drive(4'hF, 1, 1, 2'd3, 0, 1);
    drive(4'h3, 1, 0, 2'd1, 0, 1);
    drive(4'h0, 0, 0, 2'd0, 0, 0);
    @(negedge clk);
    d = 4'h8; in_valid = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1 check("async_reset", {y, y_valid, err_none, err_multi, err_cnt}, 8'd0);
    m_cnt = 2'd0;
    @(negedge clk);
    in_valid = 1'b0; d = '0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("after_reset_idle", {y, y_valid, err_none, err_multi, err_cnt}, 8'd0);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 8'(sb.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
